// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for the receiver and transmitter
// Contents:
//   rx_state_e        receiver FSM state encoding
//   UART_DATA_BITS    data bits per frame (8N1)
//   UART_OS_RATE      oversample ticks per bit
//   UART_OS_DIV_9600  system clocks per oversample tick at 100 MHz / 9600 baud
package uart_pkg;

  localparam int UART_DATA_BITS   = 8;
  localparam int UART_OS_RATE     = 16;
  localparam int UART_OS_DIV_9600 = 651;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - parameterised show-ahead byte FIFO with overrun pulse
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous active-low reset, empties the FIFO
//   push_i       write push_data_i this cycle (dropped when full without a pop)
//   push_data_i  byte to write
//   pop_i        consumer ready; pops only when the FIFO is not empty
//   data_o       head entry, forced to 0 while empty
//   valid_o      FIFO not empty
//   count_o      occupancy 0..DEPTH
//   overrun_o    one-cycle pulse after a push was dropped
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overrun_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             overrun_q;
  logic             empty, full, pop_ok, push_ok;

  // Pointers carry an extra wrap bit: equal -> empty, equal except wrap bit -> full.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop_i & ~empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push_i & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= push_i & full & ~pop_ok;
    end
  end

  // Storage needs no reset: data_o is masked while empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

  assign data_o    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign valid_o   = ~empty;
  assign count_o   = wr_ptr_q - rd_ptr_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8N1 UART receiver with show-ahead receive FIFO
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous active-low reset
//   rx_i         asynchronous serial line, idle high
//   data_o       byte at FIFO head, valid while valid_o=1
//   valid_o      FIFO not empty
//   ready_i      consumer pops the head when valid_o & ready_i
//   frame_err_o  one-cycle pulse: stop bit sampled low
//   overrun_o    one-cycle pulse: byte dropped, FIFO full
//   busy_o       receiver FSM not in IDLE
//   count_o      FIFO occupancy
module uart_rx
  import uart_pkg::*;
#(
  parameter int OS_DIV     = UART_OS_DIV_9600,
  parameter int OS_RATE    = UART_OS_RATE,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          rx_i,
  output logic [UART_DATA_BITS-1:0]     data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          frame_err_o,
  output logic                          overrun_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int                OSW       = $clog2(OS_RATE);
  localparam logic [15:0]       DIV_LAST  = 16'(OS_DIV - 1);
  localparam logic [OSW-1:0]    HALF_LAST = OSW'(OS_RATE / 2 - 1);
  localparam logic [OSW-1:0]    BIT_LAST  = OSW'(OS_RATE - 1);

  rx_state_e                  state_q;
  logic                       sync1_q, rx_s_q;
  logic [15:0]                div_q;
  logic [OSW-1:0]             os_q;
  logic [2:0]                 idx_q;
  logic [UART_DATA_BITS-1:0]  shift_q;
  logic                       frame_err_q, busy_q;
  logic                       tick, push;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      rx_s_q  <= sync1_q;
    end
  end

  assign tick = (div_q == DIV_LAST);
  // Stop-bit centre with the line high: byte goes into the FIFO on this edge.
  assign push = (state_q == STOP) && tick && (os_q == BIT_LAST) && rx_s_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      div_q       <= '0;
      os_q        <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      // Divider parks at 0 in IDLE so every frame starts phase-aligned to its falling edge.
      if (state_q == IDLE) div_q <= '0;
      else                 div_q <= tick ? '0 : div_q + 16'd1;

      case (state_q)
        IDLE: begin
          os_q <= '0;
          if (!rx_s_q) begin
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (os_q == HALF_LAST) begin
              // Re-check mid start bit; a high line here was a glitch.
              os_q  <= '0;
              idx_q <= '0;
              if (!rx_s_q) begin
                state_q <= DATA;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              os_q <= os_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            os_q <= os_q + 1'b1;  // wraps to 0 after BIT_LAST
            if (os_q == BIT_LAST) begin
              shift_q <= {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
              if (idx_q == 3'd7) state_q <= STOP;
              else               idx_q   <= idx_q + 3'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            os_q <= os_q + 1'b1;
            if (os_q == BIT_LAST) begin
              if (rx_s_q) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= BREAK;
              end
            end
          end
        end
        BREAK: begin
          // Held-low line stays here without further error pulses.
          if (rx_s_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (shift_q),
    .pop_i       (ready_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .count_o     (count_o),
    .overrun_o   (overrun_o)
  );

  assign frame_err_o = frame_err_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with OS_DIV=4 (64 clocks per bit)
module tb_uart_rx;

  localparam int BITCLK = 64;
  localparam int FRAME  = 10 * BITCLK;
  localparam int DEPTH  = 4;
  // Stop-bit centre edge lands between frame clocks 610 and 611:
  // 2 sync flops + 1 to leave IDLE, then 8+9*16 ticks of 4 clocks.
  localparam int PUSH_CLK = 610;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       rx_i = 1'b1;
  logic       ready_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, overrun_o, busy_o;
  logic [2:0] count_o;

  int checks = 0;
  int failures = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  logic [7:0] model[$];

  typedef struct {
    logic [7:0] data;
    int         exp_count;
    logic [7:0] exp_head;
    int         exp_ovr;
  } vec_t;
  vec_t tbl[5];

  uart_rx #(.OS_DIV(4), .OS_RATE(16), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o),
    .count_o     (count_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err_o) ferr_cnt++;
    if (overrun_o)   ovr_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives len clocks of an 8N1 frame starting at a negedge; ready_i pulses at clock pop_at.
  task automatic send(input logic [7:0] b, input logic stop, input int pop_at, input int len);
    for (int c = 0; c < len; c++) begin
      int bi;
      bi = c / BITCLK;
      if (bi == 0)      rx_i = 1'b0;
      else if (bi <= 8) rx_i = b[bi-1];
      else              rx_i = stop;
      ready_i = (c == pop_at);
      @(negedge clk);
    end
    ready_i = 1'b0;
  endtask

  task automatic pop_exp(input string name, input logic [7:0] exp);
    chk({name, "_valid"}, valid_o, 1'b1);
    chk({name, "_data"}, data_o, exp);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
  endtask

  task automatic model_pop();
    if (model.size() > 0) begin
      pop_exp("rnd_pop", model[0]);
      void'(model.pop_front());
    end else begin
      ready_i = 1'b1;
      @(negedge clk);
      ready_i = 1'b0;
      chk("rnd_empty_ready_count", count_o, 0);
      chk("rnd_empty_ready_valid", valid_o, 1'b0);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_valid"}, valid_o, 1'b0);
    chk({name, "_data"}, data_o, 8'h00);
    chk({name, "_count"}, count_o, 0);
    chk({name, "_busy"}, busy_o, 1'b0);
    chk({name, "_ferr"}, frame_err_o, 1'b0);
    chk({name, "_ovr"}, overrun_o, 1'b0);
  endtask

  initial begin
    int base_ovr, base_ferr, exp_ferr, exp_ovr;
    logic [7:0] b;
    logic bad;

    tbl[0] = '{8'h00, 1, 8'h00, 0};
    tbl[1] = '{8'hFF, 2, 8'h00, 0};
    tbl[2] = '{8'h5A, 3, 8'h00, 0};
    tbl[3] = '{8'h3C, 4, 8'h00, 0};
    tbl[4] = '{8'h81, 4, 8'h00, 1};

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_i = 1'b1;
    idle(5);

    // Basic byte
    send(8'hA5, 1'b1, -1, FRAME);
    chk("basic_valid", valid_o, 1'b1);
    chk("basic_data", data_o, 8'hA5);
    chk("basic_count", count_o, 1);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    chk("basic_pop_valid", valid_o, 1'b0);
    chk("basic_pop_count", count_o, 0);

    // Back-to-back frames, last one overruns the full FIFO
    base_ovr = ovr_cnt;
    for (int i = 0; i < 5; i++) begin
      send(tbl[i].data, 1'b1, -1, FRAME);
      chk($sformatf("b2b%0d_count", i), count_o, tbl[i].exp_count);
      chk($sformatf("b2b%0d_head", i), data_o, tbl[i].exp_head);
      chk($sformatf("b2b%0d_ovr", i), ovr_cnt - base_ovr, tbl[i].exp_ovr);
    end
    pop_exp("b2b_pop0", 8'h00);
    pop_exp("b2b_pop1", 8'hFF);
    pop_exp("b2b_pop2", 8'h5A);
    pop_exp("b2b_pop3", 8'h3C);
    chk("b2b_drained", valid_o, 1'b0);

    // Full FIFO with a pop on the push edge
    send(8'h11, 1'b1, -1, FRAME);
    send(8'h22, 1'b1, -1, FRAME);
    send(8'h33, 1'b1, -1, FRAME);
    send(8'h44, 1'b1, -1, FRAME);
    base_ovr = ovr_cnt;
    send(8'h77, 1'b1, PUSH_CLK, FRAME);
    chk("fullpop_ovr", ovr_cnt - base_ovr, 0);
    chk("fullpop_count", count_o, 4);
    pop_exp("fullpop_pop0", 8'h22);
    pop_exp("fullpop_pop1", 8'h33);
    pop_exp("fullpop_pop2", 8'h44);
    pop_exp("fullpop_pop3", 8'h77);

    // Glitch rejection
    base_ferr = ferr_cnt;
    rx_i = 1'b0;
    repeat (20) @(negedge clk);
    idle(100);
    chk("glitch_busy", busy_o, 1'b0);
    chk("glitch_count", count_o, 0);
    chk("glitch_ferr", ferr_cnt - base_ferr, 0);
    send(8'h42, 1'b1, -1, FRAME);
    pop_exp("glitch_then", 8'h42);

    // Framing error followed by a long break
    base_ferr = ferr_cnt;
    send(8'h33, 1'b0, -1, FRAME);
    chk("ferr_pulse", ferr_cnt - base_ferr, 1);
    chk("ferr_nopush", count_o, 0);
    rx_i = 1'b0;
    repeat (40 * BITCLK) @(negedge clk);
    chk("break_single_pulse", ferr_cnt - base_ferr, 1);
    chk("break_busy", busy_o, 1'b1);
    idle(20);
    chk("break_release_busy", busy_o, 1'b0);
    send(8'h12, 1'b1, -1, FRAME);
    chk("break_then_data", data_o, 8'h12);
    chk("break_then_count", count_o, 1);

    // Reset during DATA bit 3 with 0x12 still buffered
    send(8'hC3, 1'b1, -1, 4 * BITCLK + BITCLK / 2);
    #1 rst_i = 1'b0;
    #1 chk_reset_outputs("midreset");
    @(negedge clk);
    rx_i = 1'b1;
    rst_i = 1'b1;
    idle(10);
    send(8'h96, 1'b1, -1, FRAME);
    chk("midreset_count", count_o, 1);
    pop_exp("midreset_pop", 8'h96);
    chk("midreset_empty", valid_o, 1'b0);

    // Randomized frames against a queue model of the FIFO
    model.delete();
    exp_ferr = ferr_cnt;
    exp_ovr = ovr_cnt;
    for (int n = 0; n < 16; n++) begin
      b = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 5) == 0);
      send(b, ~bad, -1, FRAME);
      if (bad)                        exp_ferr++;
      else if (model.size() == DEPTH) exp_ovr++;
      else                            model.push_back(b);
      chk($sformatf("rnd%0d_ferr", n), ferr_cnt, exp_ferr);
      chk($sformatf("rnd%0d_ovr", n), ovr_cnt, exp_ovr);
      chk($sformatf("rnd%0d_count", n), count_o, model.size());
      rx_i = 1'b1;
      repeat ($urandom_range(0, 2)) model_pop();
      idle($urandom_range(bad ? 8 : 0, 30));
    end
    while (model.size() > 0) model_pop();
    chk("rnd_final_count", count_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the inter-board UART links: the receiving end of the 8N1 frames driven by the transmitter on each tx_a/tx_b/tx_c port.
- Oversamples the asynchronous rx line and recovers bytes, LSB first.
- Buffers received bytes in a small show-ahead FIFO that the processor's peripheral/bus logic drains through a valid/ready handshake.
- One instance per rx port inside top.

Parameters:
- OS_DIV, 651, system clocks per oversample tick (100 MHz / (16 x 9600 baud)); legal range 2..65535.
- OS_RATE, 16, oversample ticks per bit; power of two, at least 8.
- FIFO_DEPTH, 4, received-byte buffer entries; power of two, at least 2.

Ports:
- clk_i  in  1  system clock, single clock domain.
- rst_i  in  1  asynchronous, active-low reset.
- rx_i  in  1  serial line; idle high; asynchronous to clk_i.
- data_o  out  8  byte at the FIFO head; valid only while valid_o=1.
- valid_o  out  1  FIFO not empty.
- ready_i  in  1  consumer pops the head on a cycle where valid_o & ready_i.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
- overrun_o  out  1  one-cycle pulse: byte dropped because the FIFO was full.
- busy_o  out  1  high in every state other than IDLE.
- count_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst_i=0, immediate): both synchronizer flops=1, FSM=IDLE, all counters=0, FIFO emptied. Outputs: valid_o=0, data_o=0, frame_err_o=0, overrun_o=0, busy_o=0, count_o=0. Deassertion mid-frame discards the partial byte; the receiver resynchronises on the next falling edge.
- Synchronizer: rx_i passes through 2 flops; rx_s is the second flop. All decisions use rx_s only.
- Tick generator: a counter runs 0..OS_DIV-1 and pulses tick at OS_DIV-1.
  - It is held at 0 in IDLE.
  - It restarts on the IDLE->START transition.
- FSM states:
  - IDLE: rx_s==0 -> START, with the sample counter at 0.
  - START: at the OS_RATE/2 tick, rx_s==0 -> DATA (bit index 0, sample counter 0); rx_s==1 -> IDLE (glitch, no flag).
  - DATA: every OS_RATE ticks, shift rx_s into bit[idx] (LSB first). After idx=7 -> STOP.
  - STOP: at OS_RATE ticks (stop-bit centre):
    - rx_s==1 -> push the byte -> IDLE.
    - rx_s==0 -> pulse frame_err_o, discard the byte -> BREAK.
  - BREAK: wait for rx_s==1 -> IDLE. A held-low line produces exactly one frame_err_o pulse.
- Push timing:
  - The push happens on the clock edge that samples the stop bit.
  - valid_o and data_o update the next cycle.
  - End-to-end latency from rx_i edge to synchronized sample is 2 cycles.
- FIFO:
  - Show-ahead: data_o = mem[rd_ptr], with registered pointers carrying one extra wrap bit.
  - Pop only when valid_o & ready_i. ready_i while empty has no effect.
  - Push when full and no pop on the same cycle: the byte is dropped, overrun_o pulses, and stored contents are unchanged.
  - Push and pop on the same cycle when full: both succeed, no overrun, count_o unchanged.
  - Push and pop on the same cycle when empty: impossible, because valid_o=0.
  - Pointers wrap modulo FIFO_DEPTH. Full = pointers equal apart from the wrap bit.
- frame_err_o and overrun_o never occur on the same cycle: overrun can only happen on a valid stop bit.

Decomposition:
- Package uart_pkg:
  - rx_state_e enum {IDLE, START, DATA, STOP, BREAK}.
  - Constants UART_DATA_BITS=8, UART_OS_RATE=16, UART_OS_DIV_9600=651.
  - Shared with the transmitter.
- Sub-module uart_rx_fifo holds the parameterised show-ahead FIFO with push/pop/full/empty/count; it is reused by the transmitter's buffer.
- Synchronizer, tick generator and FSM stay in uart_rx.

Test Plan:
- Benches use OS_DIV=4, so 64 clocks per bit.
- Basic byte: send 0xA5 with ready_i=0 -> after the stop-bit centre, valid_o=1, data_o=0xA5, count_o=1; one ready_i cycle -> valid_o=0, count_o=0.
- Back-to-back: send 0x00, 0xFF, 0x5A, 0x3C with no idle gap, ready_i=0 -> count_o=4, pops return them in order; send 0x81 while full -> one overrun_o pulse, and the next pop still returns 0x00.
- Full with simultaneous pop: FIFO full and ready_i=1 on the push edge of 0x77 -> no overrun_o, count_o stays 4, 0x77 is the last entry out.
- Glitch rejection: 20-clock low pulse on an idle line -> FSM returns to IDLE, no push, no frame_err_o, then 0x42 received correctly.
- Framing and break: send 0x33 with the stop bit low -> single frame_err_o pulse, no push; hold rx_i low for 40 bit times -> no further pulses; release, send 0x12 -> data_o=0x12.
- Reset mid-frame: assert rst_i low during DATA bit 3 of 0xC3 -> outputs at reset values immediately; after release, a fresh 0x96 is received and the partial byte never appears.
